// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single regfile write port among NREQ write-back sources using
//   round-robin arbitration. The winning write is captured in a one-entry
//   registered stage that drives the regfile (rf_wen / rf_index_rd /
//   rf_data_rd). The compile-time option WB_BYPASS_EN adds a read-bypass
//   lookup so decode can see the staged, not-yet-written value.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   req_valid[NREQ]      requester i holds a write
//   req_ready[NREQ]      one-hot combinational grant (accept = valid & ready)
//   req_rd[NREQ*5]       dest index, requester i at [5i+4:5i]
//   req_data[NREQ*XLEN]  write data, requester i at [XLEN*i +: XLEN]
//   rf_stall             hold the output stage, no new grant
//   rf_wen/rf_index_rd/rf_data_rd   registered regfile write port
//   index_rs1/2, byp_hit1/2, byp_data1/2   bypass lookup (WB_BYPASS_EN only)
//
// XLEN comes from the `XLEN macro; 32 is used when it is not defined.
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module regfile_wb_arbiter #(
    parameter int NREQ = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*5-1:0]     req_rd,
    input  logic [NREQ*`XLEN-1:0] req_data,
    input  logic                  rf_stall,
    output logic                  rf_wen,
    output logic [4:0]            rf_index_rd,
    output logic [`XLEN-1:0]      rf_data_rd
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]            index_rs1,
    input  logic [4:0]            index_rs2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [`XLEN-1:0]      byp_data1,
    output logic [`XLEN-1:0]      byp_data2
`endif
);

    localparam int XLEN = `XLEN;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wen_q, wen_d;
    logic [4:0]      idx_q, idx_d;
    logic [XLEN-1:0] data_q, data_d;

    logic [PW:0]     scan_s;
    logic [PW-1:0]   grant_idx_s;
    logic            grant_found_s;
    logic            accept_s;
    logic [4:0]      sel_rd_s;
    logic [XLEN-1:0] sel_data_s;

    // Find the first valid requester scanning rr_ptr, rr_ptr+1, ... mod NREQ.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        scan_s        = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_s = {1'b0, rr_ptr_q} + (PW+1)'(k);
            // rr_ptr and k are both below NREQ, so one subtraction wraps.
            if (scan_s >= (PW+1)'(NREQ)) begin
                scan_s = scan_s - (PW+1)'(NREQ);
            end else begin
                scan_s = scan_s;
            end
            if (!grant_found_s && req_valid[scan_s[PW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = scan_s[PW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot grant; suppressed while stalled or held in reset.
    always_comb begin
        req_ready = '0;
        if (rstn && !rf_stall && grant_found_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign accept_s   = |req_ready;
    assign sel_rd_s   = req_rd[5*int'(grant_idx_s) +: 5];
    assign sel_data_s = req_data[XLEN*int'(grant_idx_s) +: XLEN];

    // Next state of the output stage and the round-robin pointer.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wen_d    = wen_q;
        idx_d    = idx_q;
        data_d   = data_q;
        if (rf_stall) begin
            // Stage and pointer hold; a FULL entry keeps wen high.
            wen_d = wen_q;
        end else if (accept_s) begin
            // Writes to x0 are accepted but never reach the regfile.
            wen_d  = (sel_rd_s != 5'd0);
            idx_d  = sel_rd_s;
            data_d = sel_data_s;
            if (grant_idx_s == PW'(NREQ-1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_s + PW'(1);
            end
        end else begin
            wen_d = 1'b0;
        end
    end

    // Stage and pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
            wen_q    <= 1'b0;
            idx_q    <= 5'd0;
            data_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wen_q    <= wen_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    assign rf_wen      = wen_q;
    assign rf_index_rd = idx_q;
    assign rf_data_rd  = data_q;

`ifdef WB_BYPASS_EN
    // Bypass lookup against the staged write; x0 never hits.
    always_comb begin
        byp_hit1 = wen_q && (idx_q == index_rs1) && (index_rs1 != 5'd0);
        byp_hit2 = wen_q && (idx_q == index_rs2) && (index_rs2 != 5'd0);
        if (byp_hit1) begin
            byp_data1 = data_q;
        end else begin
            byp_data1 = '0;
        end
        if (byp_hit2) begin
            byp_data2 = data_q;
        end else begin
            byp_data2 = '0;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for regfile_wb_arbiter: directed table, hand-written corner
// sequences (reset, single write, stall, bypass) and a randomized run
// compared against a behavioural model of the arbiter and staged write.
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = `XLEN;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      valid;
    logic [NREQ-1:0]      ready;
    logic [NREQ*5-1:0]    rd;
    logic [NREQ*XLEN-1:0] data;
    logic                 stall;
    logic                 wen;
    logic [4:0]           idx;
    logic [XLEN-1:0]      wdata;
`ifdef WB_BYPASS_EN
    logic [4:0]           rs1, rs2;
    logic                 hit1, hit2;
    logic [XLEN-1:0]      bd1, bd2;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (valid),
        .req_ready   (ready),
        .req_rd      (rd),
        .req_data    (data),
        .rf_stall    (stall),
        .rf_wen      (wen),
        .rf_index_rd (idx),
        .rf_data_rd  (wdata)
`ifdef WB_BYPASS_EN
        ,
        .index_rs1   (rs1),
        .index_rs2   (rs2),
        .byp_hit1    (hit1),
        .byp_hit2    (hit2),
        .byp_data1   (bd1),
        .byp_data2   (bd2)
`endif
    );

    // Simple regfile fed by the DUT write port (x0 hardwired to zero).
    logic [XLEN-1:0] tb_rf [32];
    always @(posedge clk) begin
        if (wen && idx != 5'd0) tb_rf[idx] <= wdata;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int              m_ptr;
    logic            m_wen;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;

    function automatic void model_reset();
        m_ptr = 0; m_wen = 1'b0; m_rd = 5'd0; m_data = '0;
    endfunction

    function automatic logic [NREQ-1:0] exp_grant();
        logic [NREQ-1:0] g;
        bit found;
        g = '0; found = 0;
        if (!stall) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (!found && valid[j]) begin
                    g[j] = 1'b1;
                    found = 1;
                end
            end
        end
        return g;
    endfunction

    function automatic void model_step();
        logic [NREQ-1:0] g;
        g = exp_grant();
        if (stall) return;
        if (g == '0) begin
            m_wen = 1'b0;
            return;
        end
        for (int j = 0; j < NREQ; j++) begin
            if (g[j]) begin
                m_rd   = rd[5*j +: 5];
                m_data = data[XLEN*j +: XLEN];
                m_wen  = (m_rd != 5'd0);
                m_ptr  = (j + 1) % NREQ;
            end
        end
    endfunction

    // One model-checked cycle: inputs already set at posedge+1.
    task automatic cycle();
        @(negedge clk);
        chk("rnd_ready", ready, exp_grant());
        chk("rnd_wen",   wen,   m_wen);
        chk("rnd_idx",   idx,   m_rd);
        chk("rnd_data",  wdata, m_data);
`ifdef WB_BYPASS_EN
        chk("rnd_hit1", hit1, m_wen && m_rd == rs1 && rs1 != 5'd0);
        chk("rnd_bd1",  bd1,  (m_wen && m_rd == rs1 && rs1 != 5'd0) ? m_data : '0);
        chk("rnd_hit2", hit2, m_wen && m_rd == rs2 && rs2 != 5'd0);
`endif
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; valid = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [NREQ-1:0]   valid;
        logic [NREQ*5-1:0] rd;
        logic              stall;
        logic [NREQ-1:0]   exp_ready;
        logic              exp_wen;
        logic [4:0]        exp_idx;
        logic [XLEN-1:0]   exp_data;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];
    logic [NREQ*XLEN-1:0] tdata;

    initial begin
        tdata = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        // round robin, all valid, rd=1/2/3
        vt[0]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b001, 1'b1, 5'd1, 32'hC0DE_0000};
        vt[1]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b010, 1'b1, 5'd2, 32'hC0DE_0001};
        vt[2]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b100, 1'b1, 5'd3, 32'hC0DE_0002};
        vt[3]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b001, 1'b1, 5'd1, 32'hC0DE_0000};
        vt[4]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b010, 1'b1, 5'd2, 32'hC0DE_0001};
        vt[5]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b100, 1'b1, 5'd3, 32'hC0DE_0002};
        // x0 drop from req2, then pointer back at 0
        vt[6]  = '{3'b100, {5'd0, 5'd2, 5'd1}, 1'b0, 3'b100, 1'b0, 5'd0, 32'hC0DE_0002};
        vt[7]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b001, 1'b1, 5'd1, 32'hC0DE_0000};
        // idle: wen drops, index/data hold
        vt[8]  = '{3'b000, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b000, 1'b0, 5'd1, 32'hC0DE_0000};
        // FULL with rd=7 then stalled 3 cycles, grant 0 on release
        vt[9]  = '{3'b001, {5'd3, 5'd2, 5'd7}, 1'b0, 3'b001, 1'b1, 5'd7, 32'hC0DE_0000};
        vt[10] = '{3'b001, {5'd3, 5'd2, 5'd7}, 1'b1, 3'b000, 1'b1, 5'd7, 32'hC0DE_0000};
        vt[11] = '{3'b001, {5'd3, 5'd2, 5'd7}, 1'b1, 3'b000, 1'b1, 5'd7, 32'hC0DE_0000};
        vt[12] = '{3'b001, {5'd3, 5'd2, 5'd7}, 1'b1, 3'b000, 1'b1, 5'd7, 32'hC0DE_0000};
        vt[13] = '{3'b001, {5'd3, 5'd2, 5'd7}, 1'b0, 3'b001, 1'b1, 5'd7, 32'hC0DE_0000};
        // pointer at 1: req1 wins, stall keeps pointer at 2, then req2 wins
        vt[14] = '{3'b011, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b010, 1'b1, 5'd2, 32'hC0DE_0001};
        vt[15] = '{3'b101, {5'd3, 5'd2, 5'd1}, 1'b1, 3'b000, 1'b1, 5'd2, 32'hC0DE_0001};
        vt[16] = '{3'b101, {5'd3, 5'd2, 5'd1}, 1'b0, 3'b100, 1'b1, 5'd3, 32'hC0DE_0002};
    end

    initial begin
        for (int r = 0; r < 32; r++) tb_rf[r] = '0;
        rstn = 1'b0; valid = '0; rd = '0; data = '0; stall = 1'b0;
`ifdef WB_BYPASS_EN
        rs1 = 5'd0; rs2 = 5'd0;
`endif
        #1;
        chk("reset_wen",   wen,   1'b0);
        chk("reset_idx",   idx,   5'd0);
        chk("reset_data",  wdata, '0);
        chk("reset_ready", ready, '0);
        do_reset();

        // single write from req1
        valid = 3'b010; rd = {5'd0, 5'd5, 5'd0}; data = {32'd0, 32'hDEAD_BEEF, 32'd0};
        @(negedge clk);
        chk("single_ready", ready, 3'b010);
        @(posedge clk); #1;
        valid = '0;
        chk("single_wen",  wen,   1'b1);
        chk("single_idx",  idx,   5'd5);
        chk("single_data", wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("single_rf5", tb_rf[5], 32'hDEAD_BEEF);
        chk("single_wen_drop", wen, 1'b0);

        // reset mid-accept: pointer is at 2, so req2 is staged first
        valid = 3'b111; rd = {5'd3, 5'd2, 5'd1}; data = tdata;
        @(posedge clk); #1;
        chk("pre_rst_idx", idx, 5'd3);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_wen",   wen,   1'b0);
        chk("rst_mid_idx",   idx,   5'd0);
        chk("rst_mid_data",  wdata, '0);
        chk("rst_mid_ready", ready, '0);
        valid = '0;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_no_wen", wen, 1'b0);
        valid = 3'b111;
        @(negedge clk);
        chk("post_rst_grant0", ready, 3'b001);
        @(posedge clk); #1;
        chk("post_rst_idx", idx, 5'd1);

        // directed table
        do_reset();
        data = tdata;
        for (int i = 0; i < NV; i++) begin
            valid = vt[i].valid; rd = vt[i].rd; stall = vt[i].stall;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), ready, vt[i].exp_ready);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_wen", i),  wen,   vt[i].exp_wen);
            chk($sformatf("tbl%0d_idx", i),  idx,   vt[i].exp_idx);
            chk($sformatf("tbl%0d_data", i), wdata, vt[i].exp_data);
        end
        stall = 1'b0;

`ifdef WB_BYPASS_EN
        do_reset();
        valid = 3'b001; rd = {5'd0, 5'd0, 5'd9}; data = {32'd0, 32'd0, 32'h55};
        @(posedge clk); #1;
        valid = '0; rs1 = 5'd9; rs2 = 5'd0;
        #1;
        chk("byp_hit1",  hit1, 1'b1);
        chk("byp_data1", bd1,  32'h55);
        chk("byp_hit2",  hit2, 1'b0);
        chk("byp_data2", bd2,  32'h0);
`endif

        // randomized run against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int j = 0; j < NREQ; j++) begin
                rd[5*j +: 5]         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                data[XLEN*j +: XLEN] = XLEN'($urandom);
            end
            stall = ($urandom_range(0, 4) == 0);
`ifdef WB_BYPASS_EN
            rs1 = 5'($urandom_range(0, 31));
            rs2 = m_rd;
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
